// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one write port and two
// registered read ports, an optional hard-wired zero register and a
// sequenced bulk-clear engine.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (release is synchronous to clk)
//   wr_en    write request; commits only in IDLE to a valid, non-zero index
//   wr_addr  write register index
//   wr_data  write data
//   sa, sb   read indices for ports A and B
//   da, db   read data, registered (one-cycle latency)
//   clr_req  request to zero every register (ignored while clearing)
//   busy     clear engine active; high for exactly DEPTH cycles per sweep
//   wr_drop  one-cycle pulse: the previous cycle's write was discarded
//
// Optional feature: define REGFILE_MP_BYPASS_EN to forward a same-edge
// write (or a same-edge clear of the swept index) to the read ports.
// Without it a read returns the content held before the edge.
//
// Handshake: there is no valid/ready pairing here. wr_en is a one-cycle
// request that is either committed or dropped at the edge it is sampled;
// the outcome is reported by wr_drop one cycle later. clr_req is sampled
// only in IDLE and busy stays high until the sweep finishes.

module regfile_mp #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] sa,
    input  logic [ADDR_W-1:0] sb,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] da_q, da_d;
    logic [DATA_W-1:0] db_q, db_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              wr_commit;
    logic              clr_step;
    logic              sa_ok, sb_ok, wa_ok;

    // Indices are widened to 32 bits so an out-of-range index is never
    // truncated or wrapped onto a real register.
    assign wa_ok = (32'(wr_addr) < DEPTH) && (32'(wr_addr) != ZERO_REG);
    assign sa_ok = (32'(sa) < DEPTH) && (32'(sa) != ZERO_REG);
    assign sb_ok = (32'(sb) < DEPTH) && (32'(sb) != ZERO_REG);

    assign wr_commit = wr_en && (state_q == ST_IDLE) && wa_ok;
    assign clr_step  = (state_q == ST_CLEAR);

    // Clear engine next state. A write and clr_req in the same IDLE cycle
    // both take effect: the write lands now and the sweep zeroes it later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        wr_drop_d = wr_en && !wr_commit;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read muxes. Invalid indices (out of range or the zero register)
    // always return zero, with or without forwarding.
    always_comb begin
        da_d = '0;
        db_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sa_ok && (32'(sa) == i)) da_d = regs_q[i];
            if (sb_ok && (32'(sb) == i)) db_d = regs_q[i];
        end
`ifdef REGFILE_MP_BYPASS_EN
        if (sa_ok && wr_commit && (wr_addr == sa)) da_d = wr_data;
        if (sb_ok && wr_commit && (wr_addr == sb)) db_d = wr_data;
        if (sa_ok && clr_step && (cnt_q == sa))    da_d = '0;
        if (sb_ok && clr_step && (cnt_q == sb))    db_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
            da_q      <= '0;
            db_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
            da_q      <= da_d;
            db_q      <= db_d;
        end
    end

    // Storage. A commit and a clear step never coincide: writes only
    // commit in IDLE and clear steps only happen in CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_commit && (32'(wr_addr) == i)) begin
                    regs_q[i] <= wr_data;
                end else if (clr_step && (32'(cnt_q) == i)) begin
                    regs_q[i] <= '0;
                end
            end
        end
    end

    assign da      = da_q;
    assign db      = db_q;
    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule
